// File: rtl/piso_sched.sv
// rtl/piso_sched.sv - Wishbone-programmed word FIFO feeding a parallel-in/serial-out shifter with frame strobe and IRQ.
// Bit period is div+1 cycles; div and bit order are latched per word when it is loaded.
module piso_sched #(
  parameter int BITS  = 16,
  parameter int DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        ser_out,
  output logic        ser_oeb,
  output logic        frame_o,
  output logic        irq
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic            en_q, en_d;
  logic            msb_q, msb_d;
  logic [7:0]      div_q, div_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic            die_q, die_d;
  logic            oie_q, oie_d;
  logic [BITS-1:0] mem_q [DEPTH];
  logic [BITS-1:0] mem_d [DEPTH];
  logic [PW-1:0]   rp_q, rp_d;
  logic [PW-1:0]   wp_q, wp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] sreg_q, sreg_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [7:0]      dcnt_q, dcnt_d;
  logic            cur_msb_q, cur_msb_d;
  logic [7:0]      cur_div_q, cur_div_d;

  logic        access, wr;
  logic [1:0]  rsel;
  logic        push_req, push_ok, pop;
  logic        full, empty, busy;
  logic        set_done;
  logic [3:0]  level;
  logic [31:0] rdata;
  logic        unused_ok;

  assign unused_ok = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i};

  assign access   = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr       = access & wbs_we_i;
  assign rsel     = wbs_adr_i[3:2];
  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign busy     = (state_q != S_IDLE);
  assign pop      = (state_q == S_LOAD);
  assign push_req = wr && (rsel == 2'd1);
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push_ok  = push_req && (!full || pop);
  assign level    = 4'(cnt_q);

  always_comb begin
    rdata = 32'h0;
    case (rsel)
      2'd0: rdata = {16'h0, div_q, 6'h0, msb_q, en_q};
      2'd1: rdata = 32'h0;
      2'd2: rdata = {20'h0, level, 3'h0, done_q, ovf_q, empty, full, busy};
      2'd3: rdata = {30'h0, oie_q, die_q};
      default: rdata = 32'h0;
    endcase
  end

  always_comb begin
    ack_d = access;
    dat_d = access ? rdata : 32'h0;
  end

  always_comb begin
    mem_d = mem_q;
    rp_d  = rp_q;
    wp_d  = wp_q;
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
    if (push_ok) begin
      mem_d[wp_q] = wbs_dat_i[BITS-1:0];
      wp_d        = wp_q + 1'b1;
    end
    if (pop) begin
      rp_d = rp_q + 1'b1;
    end
  end

  always_comb begin
    en_d   = en_q;
    msb_d  = msb_q;
    div_d  = div_q;
    die_d  = die_q;
    oie_d  = oie_q;
    ovf_d  = ovf_q;
    done_d = done_q;
    if (wr && rsel == 2'd0) begin
      en_d  = wbs_dat_i[0];
      msb_d = wbs_dat_i[1];
      div_d = wbs_dat_i[15:8];
    end
    if (wr && rsel == 2'd3) begin
      die_d = wbs_dat_i[0];
      oie_d = wbs_dat_i[1];
    end
    if (wr && rsel == 2'd2) begin
      if (wbs_dat_i[3]) ovf_d  = 1'b0;
      if (wbs_dat_i[4]) done_d = 1'b0;
    end
    // Set events are applied last so they win over a simultaneous clear.
    if (push_req && !push_ok) ovf_d = 1'b1;
    if (set_done) done_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_d     = bit_q;
    dcnt_d    = dcnt_q;
    cur_msb_d = cur_msb_q;
    cur_div_d = cur_div_q;
    set_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_q && !empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        sreg_d    = mem_q[rp_q];
        bit_d     = '0;
        dcnt_d    = div_q;
        cur_div_d = div_q;
        cur_msb_d = msb_q;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (dcnt_q != 8'h0) begin
          dcnt_d = dcnt_q - 8'h1;
        end else if (bit_q == BW'(BITS - 1)) begin
          state_d  = S_DONE;
          set_done = 1'b1;
        end else begin
          sreg_d = cur_msb_q ? (sreg_q << 1) : (sreg_q >> 1);
          bit_d  = bit_q + 1'b1;
          dcnt_d = cur_div_q;
        end
      end
      S_DONE: begin
        state_d = (en_q && !empty) ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= S_IDLE;
      ack_q     <= 1'b0;
      dat_q     <= 32'h0;
      en_q      <= 1'b0;
      msb_q     <= 1'b0;
      div_q     <= 8'h0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      die_q     <= 1'b0;
      oie_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rp_q      <= '0;
      wp_q      <= '0;
      cnt_q     <= '0;
      sreg_q    <= '0;
      bit_q     <= '0;
      dcnt_q    <= 8'h0;
      cur_msb_q <= 1'b0;
      cur_div_q <= 8'h0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      en_q      <= en_d;
      msb_q     <= msb_d;
      div_q     <= div_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      die_q     <= die_d;
      oie_q     <= oie_d;
      mem_q     <= mem_d;
      rp_q      <= rp_d;
      wp_q      <= wp_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      bit_q     <= bit_d;
      dcnt_q    <= dcnt_d;
      cur_msb_q <= cur_msb_d;
      cur_div_q <= cur_div_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign frame_o   = (state_q == S_SHIFT);
  assign ser_out   = (state_q == S_SHIFT) & (cur_msb_q ? sreg_q[BITS-1] : sreg_q[0]);
  assign ser_oeb   = ~en_q;
  assign irq       = (done_q & die_q) | (ovf_q & oie_q);

endmodule
